// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//   Lets two requesters share one iterative divider. A request is granted in
//   IDLE. The operands are latched and launched with a one-cycle div_start.
//   The arbiter then waits for div_complete and holds the result on the
//   owner's rsp_valid bit until that owner acks.
//
// Configuration macro:
//   DIV_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests alternate ports.
//                           undefined : fixed priority, port 0 always wins.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   req_valid[1:0]          per-requester request level
//   req_is_8_bit/_signed    per-requester mode bits
//   req_dividend0/1[31:0]   per-requester dividends
//   req_divisor0/1[15:0]    per-requester divisors
//   grant[1:0]              one-hot, one-cycle pulse: request accepted
//   rsp_valid[1:0]          one-hot, result available for that requester
//   rsp_ack[1:0]            response consumed (only the owner bit counts)
//   rsp_quotient/_remainder shared result bus, qualified by rsp_valid
//   rsp_error               shared error flag, qualified by rsp_valid
//   div_start               one-cycle launch pulse to the divider
//   div_is_8_bit/_signed    mode bits to the divider, from latched registers
//   div_dividend/_divisor   operands to the divider, from latched registers
//   div_complete/_error     divider done / error (div-by-zero, overflow)
//   div_quotient/_remainder divider results, captured on div_complete
// -----------------------------------------------------------------------------
module div_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_is_8_bit,
  input  logic [1:0]  req_is_signed,
  input  logic [31:0] req_dividend0,
  input  logic [31:0] req_dividend1,
  input  logic [15:0] req_divisor0,
  input  logic [15:0] req_divisor1,
  output logic [1:0]  grant,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ack,
  output logic [15:0] rsp_quotient,
  output logic [15:0] rsp_remainder,
  output logic        rsp_error,
  output logic        div_start,
  output logic        div_is_8_bit,
  output logic        div_is_signed,
  output logic [31:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic        div_complete,
  input  logic        div_error,
  input  logic [15:0] div_quotient,
  input  logic [15:0] div_remainder
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  typedef struct packed {
    logic        is_8_bit;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
  } op_t;

  typedef struct packed {
    logic        error;
    logic [15:0] quotient;
    logic [15:0] remainder;
  } res_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  op_t           op_q, op_d;
  res_t          res_q, res_d;
  op_t  [1:0]    req_op;
  logic [1:0]    req_live;
  logic          win;

  assign req_op[0] = {req_is_8_bit[0], req_is_signed[0], req_dividend0, req_divisor0};
  assign req_op[1] = {req_is_8_bit[1], req_is_signed[1], req_dividend1, req_divisor1};

  // grant is combinational from req_valid. Masking with reset_n keeps it low
  // while reset is held, even if a requester is already asserting.
  assign req_live = req_valid & {2{reset_n}};

`ifdef DIV_ARB_ROUND_ROBIN_EN
  // pri_q names the port that wins a tie. It flips to the loser on every grant.
  logic pri_q, pri_d;

  always_comb win = (req_live == 2'b11) ? pri_q : ~req_live[0];

  always_comb begin
    pri_d = pri_q;
    if (state_q == IDLE && req_live != 2'b00) pri_d = ~win;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pri_q <= 1'b0;
    else          pri_q <= pri_d;
  end
`else
  always_comb win = ~req_live[0];
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    res_d   = res_q;
    grant   = 2'b00;
    case (state_q)
      IDLE: begin
        if (req_live != 2'b00) begin
          grant   = win ? 2'b10 : 2'b01;
          owner_d = win;
          op_d    = req_op[win];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_complete) begin
          res_d   = {div_error, div_quotient, div_remainder};
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ack[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Operands come straight from op_q, which only loads in IDLE. They therefore
  // stay frozen for the whole ISSUE..RESPOND span.
  assign div_start     = (state_q == ISSUE);
  assign div_is_8_bit  = op_q.is_8_bit;
  assign div_is_signed = op_q.is_signed;
  assign div_dividend  = op_q.dividend;
  assign div_divisor   = op_q.divisor;

  assign rsp_valid     = (state_q == RESPOND) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_quotient  = res_q.quotient;
  assign rsp_remainder = res_q.remainder;
  assign rsp_error     = res_q.error;

endmodule
